// File: rtl/board_tile_scanner.sv
// Pixel-stream front end for the 2048 board: maps VGA coordinates to tile requests and merges renderer pixels.
// Optional macro TILE_SCAN_SNAPSHOT_EN selects the vsync-synchronised, double-buffered board update.
module board_tile_scanner #(
  parameter int          BOARD_X0  = 190,
  parameter int          BOARD_Y0  = 110,
  parameter logic [11:0] SCREEN_BG = 12'hFEE,
  parameter logic [11:0] BOARD_BG  = 12'hBA9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [63:0] board_in,
  input  logic        board_wr,
  input  logic [11:0] sprite_color,
  output logic [3:0]  tile_value,
  output logic [5:0]  tile_pos_x,
  output logic [5:0]  tile_pos_y,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        video_on_out,
  output logic        update_pending
);

  localparam logic [9:0] X0 = 10'(BOARD_X0);
  localparam logic [9:0] Y0 = 10'(BOARD_Y0);

  logic [63:0]      active_board;
  logic [9:0]       rx, ry;
  logic [7:0]       sx, sy;
  logic             in_board, in_tile;
  logic [1:0]       region;
  logic [3:0]       cur_value;
  logic [2:0][1:0]  region_q;
  logic [2:0]       vid_q, hs_q, vs_q;

  // Index 0 of each delay line holds the newest sample.
  always_comb begin
    rx        = pix_x - X0;
    ry        = pix_y - Y0;
    sx        = rx[7:0] - 8'd4;
    sy        = ry[7:0] - 8'd4;
    in_board  = (rx < 10'd260) && (ry < 10'd260);
    in_tile   = in_board && (rx >= 10'd4) && (ry >= 10'd4) &&
                (sx[5:0] < 6'd60) && (sy[5:0] < 6'd60);
    region    = in_tile ? 2'd2 : (in_board ? 2'd1 : 2'd0);
    cur_value = active_board[{sy[7:6], sx[7:6], 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tile_value   <= 4'd0;
      tile_pos_x   <= 6'd0;
      tile_pos_y   <= 6'd0;
      region_q     <= '0;
      vid_q        <= 3'b000;
      hs_q         <= 3'b111;
      vs_q         <= 3'b111;
      rgb          <= 12'h000;
      hsync_out    <= 1'b1;
      vsync_out    <= 1'b1;
      video_on_out <= 1'b0;
    end else begin
      tile_value   <= in_tile ? cur_value : 4'd0;
      tile_pos_x   <= in_tile ? sx[5:0] : 6'd0;
      tile_pos_y   <= in_tile ? sy[5:0] : 6'd0;
      region_q     <= {region_q[1:0], region};
      vid_q        <= {vid_q[1:0], video_on};
      hs_q         <= {hs_q[1:0], hsync_in};
      vs_q         <= {vs_q[1:0], vsync_in};
      hsync_out    <= hs_q[2];
      vsync_out    <= vs_q[2];
      video_on_out <= vid_q[2];
      if (!vid_q[2]) begin
        rgb <= 12'h000;
      end else begin
        case (region_q[2])
          2'd0:    rgb <= SCREEN_BG;
          2'd1:    rgb <= BOARD_BG;
          default: rgb <= sprite_color;
        endcase
      end
    end
  end

`ifdef TILE_SCAN_SNAPSHOT_EN
  logic [63:0] shadow_board;
  logic        pending;
  logic        vsync_start;

  assign vsync_start    = vs_q[1] & ~vs_q[0];
  assign update_pending = pending;

  // A write colliding with the swap lands in the shadow and keeps pending set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_board <= 64'd0;
      shadow_board <= 64'd0;
      pending      <= 1'b0;
    end else begin
      if (vsync_start && pending) begin
        active_board <= shadow_board;
      end
      if (board_wr) begin
        shadow_board <= board_in;
        pending      <= 1'b1;
      end else if (vsync_start && pending) begin
        pending <= 1'b0;
      end
    end
  end
`else
  assign update_pending = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_board <= 64'd0;
    end else if (board_wr) begin
      active_board <= board_in;
    end
  end
`endif

endmodule

// File: doc/board_tile_scanner.md
# board_tile_scanner

Pixel-stream front end for the 2048 board display. It converts VGA pixel coordinates into per-tile requests (`tile_value`, `tile_pos_x`, `tile_pos_y`) for the 60×60 sprite renderer. It merges the renderer's returned `sprite_color` with board and screen background colours, and delays sync and blank so they stay aligned with the renderer's fixed 2-cycle latency. It sits between the VGA timing generator and the RGB output pins. It owns a frame-synchronous copy of the 4×4 board.

## Interface
Parameters:
- `BOARD_X0`, default 190: left pixel column of the board area.
- `BOARD_Y0`, default 110: top pixel row of the board area.
- `SCREEN_BG`, default 12'hFEE: colour outside the board area.
- `BOARD_BG`, default 12'hBA9: colour of gaps inside the board area.

Ports:
- `clk`  in  1  pixel clock.
- `reset_n`  in  1  synchronous, active-low reset; clock `clk`.
- `pix_x`  in  10  current pixel column from the timing generator.
- `pix_y`  in  10  current pixel row from the timing generator.
- `video_on`  in  1  active-video flag from the timing generator.
- `hsync_in`  in  1  horizontal sync from the timing generator, active-low.
- `vsync_in`  in  1  vertical sync from the timing generator, active-low.
- `board_in`  in  64  new board; nibble i = tile i (i = row*4+col), encoded 0 = empty, 1 = "2", ..., 11 = "2048".
- `board_wr`  in  1  one-cycle write strobe for `board_in`.
- `sprite_color`  in  12  pixel returned by the renderer.
- `tile_value`  out  4  to the renderer.
- `tile_pos_x`  out  6  to the renderer.
- `tile_pos_y`  out  6  to the renderer.
- `rgb`  out  12  final pixel colour.
- `hsync_out`  out  1  delayed `hsync_in`.
- `vsync_out`  out  1  delayed `vsync_in`.
- `video_on_out`  out  1  delayed `video_on`.
- `update_pending`  out  1  a board write is waiting for the next frame.

## Operation
Geometry:
- Tile pitch is 64 pixels: a 60-pixel tile plus a 4-pixel gap.
- Board area is 260×260 pixels, 4-pixel outer gap included.
- rx = pix_x − BOARD_X0 and ry = pix_y − BOARD_Y0, both 10-bit unsigned.
- The pixel is in the board area iff rx < 260 and ry < 260; the unsigned subtraction wraps to a large value for pixels left of or above the board.
- sx = rx − 4 and sy = ry − 4.
- col = sx[7:6], row = sy[7:6], tx = sx[5:0], ty = sy[5:0].
- The pixel is in a tile iff it is in the board area, rx ≥ 4, ry ≥ 4, tx < 60 and ty < 60.

Region code, 2 bits:
- 0: outside the board area.
- 1: gap inside the board area.
- 2: tile.

Stage 0 (registered):
- `tile_value` = active_board nibble[row*4+col], or 0 if not in a tile.
- `tile_pos_x`/`tile_pos_y` = tx/ty, or 0 if not in a tile.
- Region code, `video_on`, `hsync_in` and `vsync_in` enter a 3-deep delay line.

Output stage (registered, three edges after stage 0):
- `rgb` = 0 if delayed video_on is 0.
- Otherwise `rgb` = SCREEN_BG, BOARD_BG or `sprite_color` for region 0, 1 or 2.

Board update:
- `board_wr` captures `board_in` into the shadow register and sets pending.
- On a vsync start (falling edge of registered `vsync_in`) with pending = 1: active_board ← shadow and pending clears.
- If `board_wr` and a vsync start happen in the same cycle: active gets the old shadow; the new write goes to the shadow; pending stays 1.

## Timing
- Inputs sampled at edge n appear on `tile_*` after edge n.
- The renderer samples `tile_*` at n+1 and presents `sprite_color` after n+2.
- `rgb`, `hsync_out`, `vsync_out` and `video_on_out` for that pixel update after edge n+3, a fixed 4-edge latency.
- Inputs are consumed every `clk`; there is no stall.
- Reset values:
  - `tile_value`, `tile_pos_x`, `tile_pos_y` = 0.
  - `rgb` = 0 and `video_on_out` = 0.
  - `hsync_out` and `vsync_out` = 1.
  - `update_pending` = 0.
  - Active board, shadow and delay line cleared; delayed syncs reset to 1.
- Reset asserted mid-frame: outputs hold the reset values while `reset_n` = 0; the next frame renders an empty board.

## Configuration
- `TILE_SCAN_SNAPSHOT_EN` defined: the double-buffered, vsync-synchronised update described above.
- Not defined:
  - `board_wr` writes `board_in` directly into active_board on the next edge, so mid-frame tearing is allowed.
  - There is no shadow register.
  - `update_pending` is tied to 0.

## Test plan
- Reset: hold `reset_n` = 0 for 3 cycles → `rgb` = 0, syncs = 1, `tile_value` = 0, `update_pending` = 0.
- Tile address: board nibble 5 = 3, pix = (BOARD_X0+4+64+10, BOARD_Y0+4+64+20) = (268, 198), `video_on` = 1 → next cycle `tile_value` = 3, `tile_pos_x` = 10, `tile_pos_y` = 20; `rgb` equals the `sprite_color` driven 3 edges after input.
- Gaps and edges:
  - pix = (BOARD_X0+64, BOARD_Y0+10) = (254, 120) → `rgb` = 12'hBA9 and `tile_value` = 0.
  - pix = (189, 200) → `rgb` = 12'hFEE.
  - pix = (450, 200) → `rgb` = 12'hFEE.
- Blanking: `video_on` = 0 inside a tile → `rgb` = 0 after 4 edges; `hsync_out` follows the `hsync_in` pulse delayed exactly 4 edges.
- Snapshot (macro on): `board_wr` mid-frame with tile 0 = 1 → `update_pending` = 1 and tile 0 still reads 0 for the rest of the frame; after the vsync falling edge tile 0 reads 1 and pending = 0.
- Collision: `board_wr` in the same cycle as the vsync start → active takes the prior shadow, pending stays 1, and the new value appears after the following vsync. Macro off: the write is visible on the next edge.
